// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and status register
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] dataAddr,
    input  logic [31:0] writeData,
    input  logic        we,
    output logic [31:0] readData,
    output logic        hit,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BAUD   = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic          overflow;

    logic [1:0]    state;
    logic [BW-1:0] baudCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic          txReg;

    logic hitData;
    logic hitStatus;
    logic full;
    logic empty;
    logic pushReq;
    logic pushOk;
    logic pop;
    logic baudDone;
    logic unusedWriteBits;

    assign hitData   = (dataAddr == BASE_ADDR);
    assign hitStatus = (dataAddr == STATUS_ADDR);
    assign hit       = hitData | hitStatus;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign baudDone = (baudCnt == LAST_BAUD);

    // Acceptance looks only at the pre-edge count, so a pop in the same edge cannot rescue a full push.
    assign pushReq = we & hitData;
    assign pushOk  = pushReq & ~full;
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & baudDone));

    assign unusedWriteBits = ^writeData[31:8];

    always_comb begin
        readData = '0;
        if (hitStatus) begin
            readData = {16'h0000, 8'(count), 4'h0, overflow, (state != IDLE), empty, full};
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= writeData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + CW'(pushOk) - CW'(pop);
            if (pushReq && full) begin
                overflow <= 1'b1;
            end else if (we && hitStatus && writeData[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state    <= IDLE;
            baudCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            txReg    <= 1'b1;
        end else begin
            txReg <= (state == START) ? 1'b0 : (state == DATA) ? shiftReg[0] : 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        baudCnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        bitCnt  <= '0;
                        state   <= DATA;
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        baudCnt  <= '0;
                        shiftReg <= shiftReg >> 1;
                        if (bitCnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baudDone) begin
                        baudCnt <= '0;
                        if (pop) begin
                            shiftReg <= fifoMem[rdPtr];
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baudCnt <= baudCnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx = txReg;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized self-checking bench for mmio_uart_tx against a frame-level model
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [31:0] writeData = '0;
    logic        we = 1'b0;
    logic [31:0] readData;
    logic        hit;
    logic        tx;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] q[$];
    int         busyLeft = 0;
    logic [7:0] curByte = '0;
    logic       ovf = 1'b0;
    logic       txModel = 1'b1;

    int txAt[0:599];

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .dataAddr(dataAddr),
        .writeData(writeData),
        .we(we),
        .readData(readData),
        .hit(hit),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        int cnt;
        cnt = q.size();
        return {16'h0000, 8'(cnt), 4'h0, ovf, (busyLeft != 0), (cnt == 0), (cnt == DEPTH)};
    endfunction

    // One frame is FRAME cycles of busy; the serializer takes a new byte whenever it is idle or finishing.
    task automatic modelEdge(input logic rstn, input logic weIn, input logic [31:0] a, input logic [31:0] d);
        int pre;
        int idx;
        if (!rstn) begin
            q.delete();
            busyLeft = 0;
            ovf = 1'b0;
            txModel = 1'b1;
            return;
        end
        if (busyLeft == 0) begin
            txModel = 1'b1;
        end else begin
            idx = (FRAME - busyLeft) / CPB;
            txModel = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : curByte[idx-1];
        end
        pre = q.size();
        if (pre > 0 && busyLeft <= 1) begin
            curByte = q.pop_front();
            busyLeft = FRAME;
        end else if (busyLeft > 0) begin
            busyLeft--;
        end
        if (weIn && a == BASE) begin
            if (pre == DEPTH) ovf = 1'b1;
            else q.push_back(d[7:0]);
        end else if (weIn && a == BASE + 32'd4 && d[3]) begin
            ovf = 1'b0;
        end
    endtask

    task automatic step(input logic rstn, input logic weIn, input logic [31:0] a, input logic [31:0] d);
        n_reset = rstn;
        we = weIn;
        dataAddr = a;
        writeData = d;
        #2;
        checkVal("hit", {31'b0, hit}, {31'b0, (a == BASE) || (a == BASE + 32'd4)});
        checkVal("readData", readData, (a == BASE + 32'd4) ? modelStatus() : 32'h0);
        @(posedge clk);
        modelEdge(rstn, weIn, a, d);
        #1;
        checkVal("tx", {31'b0, tx}, {31'b0, txModel});
    endtask

    task automatic peekStatus(input string tag, input logic [31:0] exp);
        we = 1'b0;
        dataAddr = BASE + 32'd4;
        #1;
        checkVal(tag, readData, exp);
    endtask

    initial begin
        int n;
        int busyCnt;
        int fallIdx;
        int wePeriod;
        logic [31:0] a;

        repeat (2) @(posedge clk);
        #1;

        step(1'b0, 1'b1, BASE, 32'h12);
        step(1'b0, 1'b1, BASE, 32'h34);
        checkVal("rst_tx", {31'b0, tx}, 32'h1);
        step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        peekStatus("rst_status", 32'h0000_0002);

        step(1'b1, 1'b1, BASE, 32'hFFFF_FF55);
        txAt[0] = tx;
        busyCnt = 0;
        fallIdx = -1;
        for (int i = 1; i < 50; i++) begin
            step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
            txAt[i] = tx;
            if (readData[2]) busyCnt++;
            if (fallIdx < 0 && tx == 1'b0) fallIdx = i;
        end
        checkVal("latency", fallIdx, 2);
        checkVal("busy_cycles", busyCnt, 40);
        for (int b = 0; b < 8; b++) begin
            checkVal("bit55", txAt[6 + 4*b + 2], (b % 2 == 0) ? 32'd1 : 32'd0);
        end
        checkVal("stop55", txAt[40], 1);
        peekStatus("idle_status", 32'h0000_0002);

        step(1'b1, 1'b1, BASE, 32'h41);
        txAt[0] = tx;
        step(1'b1, 1'b1, BASE, 32'h42);
        txAt[1] = tx;
        for (int i = 2; i < 100; i++) begin
            step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
            txAt[i] = tx;
        end
        checkVal("b2b_start1", txAt[2], 0);
        checkVal("b2b_stop1", txAt[41], 1);
        checkVal("b2b_start2", txAt[42], 0);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, BASE, 32'h60 + i);
        end
        peekStatus("ovf_status", 32'h0000_080D);
        step(1'b1, 1'b1, BASE + 32'd4, 32'h8);
        peekStatus("ovf_clear", 32'h0000_0805);
        for (int i = 0; i < 9 * FRAME + 10; i++) begin
            step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        end
        peekStatus("ovf_drained", 32'h0000_0002);

        step(1'b1, 1'b1, BASE + 32'd8, 32'h77);
        checkVal("hit_plus8", {31'b0, hit}, 32'h0);
        checkVal("rd_plus8", readData, 32'h0);
        step(1'b1, 1'b1, BASE - 32'd4, 32'h78);
        checkVal("hit_minus4", {31'b0, hit}, 32'h0);
        peekStatus("decode_nopush", 32'h0000_0002);
        checkVal("hit_status", {31'b0, hit}, 32'h1);

        step(1'b1, 1'b1, BASE, 32'hA5);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 1'b0, BASE, 32'h0);
        end
        step(1'b0, 1'b0, BASE, 32'h0);
        checkVal("rst_mid_tx", {31'b0, tx}, 32'h1);
        step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        peekStatus("rst_mid_status", 32'h0000_0002);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        end

        for (int i = 0; i < 3000; i++) begin
            wePeriod = (i < 1500) ? 16 : 4;
            n = $urandom_range(0, 9);
            if (n < 4) a = BASE;
            else if (n < 7) a = BASE + 32'd4;
            else if (n == 7) a = BASE + 32'd8;
            else if (n == 8) a = BASE - 32'd4;
            else a = $urandom;
            step(($urandom % 500) != 0, ($urandom % wePeriod) == 0, a, $urandom);
        end
        for (int i = 0; i < (DEPTH + 1) * FRAME + 5; i++) begin
            step(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        end
        peekStatus("final_status", {16'h0, 8'h00, 4'h0, ovf, 3'b010});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
